memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage of the five-stage RV32I pipeline, between execute and writeback. It accepts one `execute_to_memory_t` per handshake and performs loads and stores over a valid/ready data-memory port. Load data is aligned and sign- or zero-extended. The stage emits one registered `memory_to_writeback_t` per instruction and stalls execute while a memory transaction is outstanding.

## Interface

Parameters:
- `ADDR_WIDTH`, default `MEM_ADDRESS_WIDTH` (32): data-memory address width.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_data`  in  `execute_to_memory_t`  instruction, `alu_result` (effective address), `rs2_value` (store data), `branch_target`.
- `mem_ready`  out  1  stage can accept; handshake occurs when `ex_valid & mem_ready`.
- `wb_valid`  out  1  one-cycle pulse per completed instruction.
- `wb_data`  out  `memory_to_writeback_t`  result; `alu_result` carries load data for loads.
- `mem_fault`  out  1  pulses with `wb_valid` for a misaligned or illegal-funct3 access.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  memory accepts the request.
- `dmem_addr`  out  `ADDR_WIDTH`  byte address.
- `dmem_we`  out  1  1 = store.
- `dmem_wstrb`  out  4  byte enables.
- `dmem_wdata`  out  32  store data, lane-replicated.
- `dmem_rsp_valid`  in  1  load data valid; arrives at the earliest one cycle after request acceptance.
- `dmem_rsp_data`  in  32  aligned word read from `addr & ~3`.

## Operation

- States: IDLE, REQ, WAIT_RSP. `mem_ready = (state == IDLE)`.
- IDLE with handshake:
  - Non-memory opcode: register `decoded_instruction`, `alu_result` and `branch_target` into `wb_data`. `wb_valid = 1` next cycle. Stay in IDLE.
  - `OP_LOAD` or `OP_STORE`, aligned and legal: latch the request registers and go to REQ.
  - `OP_LOAD` or `OP_STORE`, misaligned or illegal: no request is issued. Next cycle `wb_valid = 1`, `mem_fault = 1`, and `wb_data.decoded_instruction.rd` is forced to 0. Stay in IDLE.
- Misalignment and legality rules:
  - LH, LHU, SH: fault when `addr[0] = 1`.
  - LW, SW: fault when `addr[1:0] != 0`.
  - Load funct3 3, 6 or 7: illegal. Store funct3 above 2: illegal.
- REQ:
  - `dmem_req_valid = 1`. `addr`, `we`, `wstrb` and `wdata` are held stable until `dmem_req_ready`.
  - Store accepted: `wb_valid` next cycle, go to IDLE.
  - Load accepted: go to WAIT_RSP.
- WAIT_RSP: on `dmem_rsp_valid`, register the extended load data into `wb_data.alu_result`, pulse `wb_valid` next cycle, go to IDLE.
- Store lanes:
  - SB: `wstrb = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wstrb = 4'b0011 << addr[1:0]`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wstrb = 4'b1111`, `wdata = rs2`.
- Load extract: `sh = rsp_data >> (8*addr[1:0])`.
  - LB: sign-extend `sh[7:0]`. LBU: zero-extend `sh[7:0]`.
  - LH: sign-extend `sh[15:0]`. LHU: zero-extend `sh[15:0]`.
  - LW: `rsp_data`.
- For non-faulting instructions `wb_data.decoded_instruction` and `branch_target` pass through unchanged.
- `ex_valid` while `mem_ready = 0` is ignored. Upstream holds its data.
- `dmem_rsp_valid` outside WAIT_RSP is ignored.

## Timing

- Reset values:
  - state IDLE.
  - `wb_valid`, `mem_fault`, `dmem_req_valid`, `dmem_we` = 0.
  - `wb_data`, `dmem_addr`, `dmem_wstrb`, `dmem_wdata` = 0.
  - `mem_ready = 1` in the cycle after reset deasserts.
- Reset mid-transaction (REQ or WAIT_RSP): the instruction is dropped with no `wb_valid`, and `dmem_req_valid` drops the next cycle.
- Latency, with handshake in cycle N:
  - Non-memory and fault cases: `wb_valid` at N+1. Throughput is 1 per cycle back-to-back.
  - Store: `dmem_req_valid` from N+1. With acceptance at M ≥ N+1, `wb_valid` at M+1.
  - Load: with response at R, `wb_valid` at R+1.
- In the cycle FSM returns to IDLE (same cycle `wb_valid` rises), `mem_ready = 1` and a new handshake may occur.
- `wb_data` holds its last value when `wb_valid = 0`. `wb_valid` is never high for two cycles for the same instruction.

## Test plan

- Two back-to-back `OP_ARITHMETIC` instructions, `alu_result` 0x11 then 0x22 → `wb_valid` high two consecutive cycles carrying 0x11, 0x22. `mem_ready` stays 1. No `dmem_req_valid`.
- SB to 0x1003 with `rs2 = 0x000000AB`, `dmem_req_ready` low for 2 cycles → `wstrb = 4'b1000` and `wdata = 0xABABABAB`, both stable through the wait. `wb_valid` the cycle after acceptance. `mem_ready` low throughout.
- LB from 0x2001 with `rsp_data = 0x000080FF` → `alu_result = 0xFFFFFF80`. Repeat as LBU → 0x00000080. LH from 0x2002 with `rsp_data = 0x8001_0000` → 0xFFFF8001.
- LH from 0x0003 → no request, `wb_valid` with `mem_fault = 1`, `rd = 0`. SW to 0x0002 → same response.
- LW with response 3 cycles after acceptance while the next instruction is held on `ex_valid` → `mem_ready = 0` until the `wb_valid` cycle. The held instruction is accepted in that cycle and completes at the next edge.
- Reset asserted during WAIT_RSP, then a stray `dmem_rsp_valid` after reset → no `wb_valid`. All outputs at reset values. `mem_ready = 1`.

Source files
------------

// File: rtl/memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// memory_stage : RV32I memory-access stage, loads/stores over a valid/ready
//                data-memory port with load alignment and extension.
// Rev 1.0
// ----------------------------------------------------------------------------
package memory_stage_pkg;
  localparam int MEM_ADDRESS_WIDTH = 32;

  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_STORE      = 7'b0100011;
  localparam logic [6:0] OP_ARITHMETIC = 7'b0110011;
  localparam logic [6:0] OP_IMMEDIATE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH     = 7'b1100011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } decoded_instruction_t;

  typedef struct packed {
    decoded_instruction_t decoded_instruction;
    logic [31:0]          alu_result;
    logic [31:0]          rs2_value;
    logic [31:0]          branch_target;
  } execute_to_memory_t;

  typedef struct packed {
    decoded_instruction_t decoded_instruction;
    logic [31:0]          alu_result;
    logic [31:0]          branch_target;
  } memory_to_writeback_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  execute_to_memory_t    ex_data,
  output logic                  mem_ready,
  output logic                  wb_valid,
  output memory_to_writeback_t  wb_data,
  output logic                  mem_fault,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [3:0]            dmem_wstrb,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [31:0]           dmem_rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t                r_state;
  decoded_instruction_t  r_inst;
  logic [31:0]           r_alu;
  logic [31:0]           r_bt;
  logic                  r_wb_valid;
  memory_to_writeback_t  r_wb_data;
  logic                  r_mem_fault;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata;

  logic [2:0]            w_f3;
  logic [1:0]            w_lo;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_fault;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_wdata;
  decoded_instruction_t  w_fault_inst;
  logic [31:0]           w_rsp_sh;
  logic [31:0]           w_load;

  assign w_f3       = ex_data.decoded_instruction.funct3;
  assign w_lo       = ex_data.alu_result[1:0];
  assign w_is_load  = (ex_data.decoded_instruction.opcode == OP_LOAD);
  assign w_is_store = (ex_data.decoded_instruction.opcode == OP_STORE);

  // Alignment/legality and store lane placement for the incoming instruction
  always_comb begin
    w_fault = 1'b0;
    if (w_is_load) begin
      case (w_f3)
        3'd0, 3'd4: w_fault = 1'b0;
        3'd1, 3'd5: w_fault = w_lo[0];
        3'd2:       w_fault = (w_lo != 2'd0);
        default:    w_fault = 1'b1;
      endcase
    end else if (w_is_store) begin
      case (w_f3)
        3'd0:    w_fault = 1'b0;
        3'd1:    w_fault = w_lo[0];
        3'd2:    w_fault = (w_lo != 2'd0);
        default: w_fault = 1'b1;
      endcase
    end

    w_wstrb = 4'b1111;
    w_wdata = ex_data.rs2_value;
    case (w_f3)
      3'd0: begin
        w_wstrb = 4'b0001 << w_lo;
        w_wdata = {4{ex_data.rs2_value[7:0]}};
      end
      3'd1: begin
        w_wstrb = 4'b0011 << w_lo;
        w_wdata = {2{ex_data.rs2_value[15:0]}};
      end
      default: ;
    endcase

    w_fault_inst    = ex_data.decoded_instruction;
    w_fault_inst.rd = 5'd0;
  end

  // Faulting accesses never reach WAIT_RSP, so LW always sees a zero shift here
  always_comb begin
    w_rsp_sh = dmem_rsp_data >> {r_alu[1:0], 3'b000};
    case (r_inst.funct3)
      3'd0:    w_load = {{24{w_rsp_sh[7]}}, w_rsp_sh[7:0]};
      3'd1:    w_load = {{16{w_rsp_sh[15]}}, w_rsp_sh[15:0]};
      3'd4:    w_load = {24'd0, w_rsp_sh[7:0]};
      3'd5:    w_load = {16'd0, w_rsp_sh[15:0]};
      default: w_load = w_rsp_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_inst      <= '0;
      r_alu       <= '0;
      r_bt        <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_mem_fault <= 1'b0;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_mem_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!(w_is_load || w_is_store)) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= '{decoded_instruction: ex_data.decoded_instruction,
                              alu_result:          ex_data.alu_result,
                              branch_target:       ex_data.branch_target};
            end else if (w_fault) begin
              r_wb_valid  <= 1'b1;
              r_mem_fault <= 1'b1;
              r_wb_data   <= '{decoded_instruction: w_fault_inst,
                               alu_result:          ex_data.alu_result,
                               branch_target:       ex_data.branch_target};
            end else begin
              r_inst      <= ex_data.decoded_instruction;
              r_alu       <= ex_data.alu_result;
              r_bt        <= ex_data.branch_target;
              r_req_valid <= 1'b1;
              r_addr      <= ex_data.alu_result[ADDR_WIDTH-1:0];
              r_we        <= w_is_store;
              r_wstrb     <= w_is_store ? w_wstrb : 4'b0000;
              r_wdata     <= w_is_store ? w_wdata : 32'd0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            if (r_we) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= '{decoded_instruction: r_inst,
                              alu_result:          r_alu,
                              branch_target:       r_bt};
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_WAIT_RSP;
            end
          end
        end
        S_WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= '{decoded_instruction: r_inst,
                            alu_result:          w_load,
                            branch_target:       r_bt};
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready      = (r_state == S_IDLE);
  assign wb_valid       = r_wb_valid;
  assign wb_data        = r_wb_data;
  assign mem_fault      = r_mem_fault;
  assign dmem_req_valid = r_req_valid;
  assign dmem_addr      = r_addr;
  assign dmem_we        = r_we;
  assign dmem_wstrb     = r_wstrb;
  assign dmem_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_memory_stage : directed and randomized checks of memory_stage.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ex_valid;
  execute_to_memory_t   ex_data;
  logic                 mem_ready;
  logic                 wb_valid;
  memory_to_writeback_t wb_data;
  logic                 mem_fault;
  logic                 dmem_req_valid;
  logic                 dmem_req_ready;
  logic [31:0]          dmem_addr;
  logic                 dmem_we;
  logic [3:0]           dmem_wstrb;
  logic [31:0]          dmem_wdata;
  logic                 dmem_rsp_valid;
  logic [31:0]          dmem_rsp_data;

  logic rand_mem = 1'b0;
  int   n_total  = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_data        (ex_data),
    .mem_ready      (mem_ready),
    .wb_valid       (wb_valid),
    .wb_data        (wb_data),
    .mem_fault      (mem_fault),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference rules ----------------
  function automatic bit is_mem(input execute_to_memory_t d);
    return (d.decoded_instruction.opcode == OP_LOAD) || (d.decoded_instruction.opcode == OP_STORE);
  endfunction

  function automatic bit faulty(input execute_to_memory_t d);
    int f = int'(d.decoded_instruction.funct3);
    int a = int'(d.alu_result[1:0]);
    if (d.decoded_instruction.opcode == OP_LOAD) begin
      if (f == 0 || f == 4) return 1'b0;
      if (f == 1 || f == 5) return (a % 2) != 0;
      if (f == 2) return a != 0;
      return 1'b1;
    end
    if (f == 0) return 1'b0;
    if (f == 1) return (a % 2) != 0;
    if (f == 2) return a != 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] strb(input execute_to_memory_t d);
    int a = int'(d.alu_result[1:0]);
    case (d.decoded_instruction.funct3)
      3'd0:    return 4'(1 << a);
      3'd1:    return 4'(3 << a);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdat(input execute_to_memory_t d);
    logic [31:0] r = d.rs2_value;
    case (d.decoded_instruction.funct3)
      3'd0:    return {4{r[7:0]}};
      3'd1:    return {2{r[15:0]}};
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] ldval(input logic [2:0] f3, input logic [1:0] a,
                                        input logic [31:0] rsp);
    logic [31:0] s = rsp >> (8 * int'(a));
    case (f3)
      3'd0:    return s[7]  ? {24'hFFFFFF, s[7:0]}  : {24'h0, s[7:0]};
      3'd1:    return s[15] ? {16'hFFFF, s[15:0]}   : {16'h0, s[15:0]};
      3'd4:    return {24'h0, s[7:0]};
      3'd5:    return {16'h0, s[15:0]};
      default: return rsp;
    endcase
  endfunction

  function automatic execute_to_memory_t mk(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [31:0] alu, input logic [31:0] rs2);
    execute_to_memory_t d;
    d = '0;
    d.decoded_instruction.opcode = op;
    d.decoded_instruction.funct3 = f3;
    d.decoded_instruction.rd     = 5'd7;
    d.decoded_instruction.rs1    = 5'd3;
    d.alu_result                 = alu;
    d.rs2_value                  = rs2;
    d.branch_target              = 32'hB000_0000 ^ alu;
    return d;
  endfunction

  function automatic execute_to_memory_t rnd();
    execute_to_memory_t d;
    d = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0: d.decoded_instruction.opcode = OP_LOAD;
      1: d.decoded_instruction.opcode = OP_STORE;
      2: d.decoded_instruction.opcode = OP_ARITHMETIC;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) d.alu_result[1:0] = 2'b00;
    if ($urandom_range(0, 1) == 1) d.decoded_instruction.funct3 = 3'($urandom_range(0, 2));
    return d;
  endfunction

  // ---------------- cycle model and comparator ----------------
  logic                 m_on  = 1'b0;
  logic                 e_v   = 1'b0;
  logic                 e_f   = 1'b0;
  logic                 e_rst = 1'b0;
  logic                 busy  = 1'b0;
  logic                 acc   = 1'b0;
  memory_to_writeback_t e_wb  = '0;
  execute_to_memory_t   cur   = '0;

  always @(negedge clk) begin
    if (m_on) begin
      chkb("mem_ready", mem_ready, !busy);
      chkb("wb_valid", wb_valid, e_v);
      chkb("mem_fault", mem_fault, e_f);
      chk("wb_alu", wb_data.alu_result, e_wb.alu_result);
      chk("wb_bt", wb_data.branch_target, e_wb.branch_target);
      chk("wb_inst", wb_data.decoded_instruction, e_wb.decoded_instruction);
      chkb("req_valid", dmem_req_valid, busy && !acc);
      if (busy && !acc) begin
        chk("req_addr", dmem_addr, cur.alu_result);
        chkb("req_we", dmem_we, cur.decoded_instruction.opcode == OP_STORE);
        if (cur.decoded_instruction.opcode == OP_STORE) begin
          chk("req_wstrb", 32'(dmem_wstrb), 32'(strb(cur)));
          chk("req_wdata", dmem_wdata, wdat(cur));
        end
      end
      if (e_rst) begin
        chk("rst_addr", dmem_addr, 32'd0);
        chkb("rst_we", dmem_we, 1'b0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
      end
    end
    e_v = 1'b0; e_f = 1'b0; e_rst = 1'b0;
    if (reset) begin
      m_on = 1'b1; e_rst = 1'b1; busy = 1'b0; acc = 1'b0; e_wb = '0;
    end else if (m_on) begin
      if (busy && !acc) begin
        if (dmem_req_ready) begin
          if (cur.decoded_instruction.opcode == OP_STORE) begin
            e_v  = 1'b1;
            busy = 1'b0;
            e_wb.decoded_instruction = cur.decoded_instruction;
            e_wb.alu_result          = cur.alu_result;
            e_wb.branch_target       = cur.branch_target;
          end else begin
            acc = 1'b1;
          end
        end
      end else if (busy) begin
        if (dmem_rsp_valid) begin
          e_v  = 1'b1;
          busy = 1'b0;
          e_wb.decoded_instruction = cur.decoded_instruction;
          e_wb.alu_result = ldval(cur.decoded_instruction.funct3, cur.alu_result[1:0], dmem_rsp_data);
          e_wb.branch_target = cur.branch_target;
        end
      end else if (ex_valid) begin
        cur = ex_data;
        if (!is_mem(cur) || faulty(cur)) begin
          e_v = 1'b1;
          e_f = is_mem(cur);
          e_wb.decoded_instruction = cur.decoded_instruction;
          if (e_f) e_wb.decoded_instruction.rd = 5'd0;
          e_wb.alu_result    = cur.alu_result;
          e_wb.branch_target = cur.branch_target;
        end else begin
          busy = 1'b1;
          acc  = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_mem) begin
      dmem_req_ready = ($urandom_range(0, 2) == 0);
      dmem_rsp_valid = ($urandom_range(0, 2) == 0);
      dmem_rsp_data  = $urandom;
    end
  endtask

  task automatic send(input execute_to_memory_t d);
    int n = 0;
    ex_valid = 1'b1;
    ex_data  = d;
    while (!mem_ready && n < 200) begin
      cyc();
      n++;
    end
    if (!mem_ready) chkb("handshake_timeout", mem_ready, 1'b1);
    cyc();
    ex_valid = 1'b0;
  endtask

  task automatic load_op(input execute_to_memory_t d, input int gap, input logic [31:0] data);
    dmem_req_ready = 1'b1;
    send(d);
    cyc();
    dmem_req_ready = 1'b0;
    repeat (gap) cyc();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = data;
    cyc();
    dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;

    chk("pin_lb", ldval(3'd0, 2'd1, 32'h0000_80FF), 32'hFFFF_FF80);
    chk("pin_lh", ldval(3'd1, 2'd2, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_sb_strb", 32'(strb(mk(OP_STORE, 3'd0, 32'h1003, 32'hAB))), 32'h8);
    chk("pin_sb_wdata", wdat(mk(OP_STORE, 3'd0, 32'h1003, 32'hAB)), 32'hABAB_ABAB);
    chkb("pin_lh_fault", faulty(mk(OP_LOAD, 3'd1, 32'h3, 32'h0)), 1'b1);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chkb("d_rst_ready", mem_ready, 1'b1);
    chkb("d_rst_wbv", wb_valid, 1'b0);

    send(mk(OP_ARITHMETIC, 3'd0, 32'h11, 32'h0));
    chkb("d_arith1_v", wb_valid, 1'b1);
    chk("d_arith1", wb_data.alu_result, 32'h11);
    send(mk(OP_ARITHMETIC, 3'd0, 32'h22, 32'h0));
    chkb("d_arith2_v", wb_valid, 1'b1);
    chk("d_arith2", wb_data.alu_result, 32'h22);
    chkb("d_arith_ready", mem_ready, 1'b1);

    dmem_req_ready = 1'b0;
    send(mk(OP_STORE, 3'd0, 32'h1003, 32'h0000_00AB));
    for (int i = 0; i < 3; i++) begin
      chk("d_sb_wstrb", 32'(dmem_wstrb), 32'h8);
      chk("d_sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      chkb("d_sb_busy", mem_ready, 1'b0);
      if (i == 2) dmem_req_ready = 1'b1;
      else cyc();
    end
    cyc();
    dmem_req_ready = 1'b0;
    chkb("d_sb_wbv", wb_valid, 1'b1);

    load_op(mk(OP_LOAD, 3'd0, 32'h2001, 32'h0), 0, 32'h0000_80FF);
    chk("d_lb", wb_data.alu_result, 32'hFFFF_FF80);
    load_op(mk(OP_LOAD, 3'd4, 32'h2001, 32'h0), 1, 32'h0000_80FF);
    chk("d_lbu", wb_data.alu_result, 32'h0000_0080);
    load_op(mk(OP_LOAD, 3'd1, 32'h2002, 32'h0), 0, 32'h8001_0000);
    chk("d_lh", wb_data.alu_result, 32'hFFFF_8001);

    send(mk(OP_LOAD, 3'd1, 32'h0003, 32'h0));
    chkb("d_lhf_fault", mem_fault, 1'b1);
    chk("d_lhf_rd", 32'(wb_data.decoded_instruction.rd), 32'd0);
    chkb("d_lhf_noreq", dmem_req_valid, 1'b0);
    send(mk(OP_STORE, 3'd2, 32'h0002, 32'h5));
    chkb("d_swf_fault", mem_fault, 1'b1);
    chkb("d_swf_v", wb_valid, 1'b1);

    dmem_req_ready = 1'b1;
    send(mk(OP_LOAD, 3'd2, 32'h3000, 32'h0));
    cyc();
    dmem_req_ready = 1'b0;
    ex_valid = 1'b1;
    ex_data  = mk(OP_ARITHMETIC, 3'd0, 32'h33, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chkb("d_lw_stall", mem_ready, 1'b0);
      if (i < 2) cyc();
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hCAFE_F00D;
    cyc();
    dmem_rsp_valid = 1'b0;
    chkb("d_lw_ready", mem_ready, 1'b1);
    chk("d_lw", wb_data.alu_result, 32'hCAFE_F00D);
    cyc();
    ex_valid = 1'b0;
    chk("d_held", wb_data.alu_result, 32'h33);

    dmem_req_ready = 1'b1;
    send(mk(OP_LOAD, 3'd2, 32'h4000, 32'h0));
    cyc();
    dmem_req_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    dmem_rsp_valid = 1'b1;
    chkb("d_rr_wbv", wb_valid, 1'b0);
    chk("d_rr_alu", wb_data.alu_result, 32'd0);
    chkb("d_rr_ready", mem_ready, 1'b1);
    cyc();
    dmem_rsp_valid = 1'b0;
    chkb("d_rr_stray", wb_valid, 1'b0);

    rand_mem = 1'b1;
    for (int i = 0; i < 500; i++) begin
      send(rnd());
      if ($urandom_range(0, 3) == 0) cyc();
    end
    repeat (40) cyc();
    rand_mem = 1'b0;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
